debug_loader: RTL and testbench

- Host-side debug controller for the MIPS pipeline top.
- Receives a program byte-stream from a UART receiver and assembles it into 32-bit words. Writes the words into instruction memory through the pipeline's debug load port (debug flag, instruction address, instruction data, write enable).
- After loading, releases the CPU to run, waits for the pipeline halt flag or a watchdog timeout, then reports status and final PC through a UART transmitter.
- Sits between uart_rx/uart_tx and the MIPS top; it drives the load interface the pipeline consumes.

---
 rtl/debug_loader.sv | 200 ++++++++++++++++++++
 tb/tb_debug_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_loader.sv
// debug_loader: host-side debug controller for the MIPS pipeline.
// Assembles UART bytes into instruction words, writes them through the
// pipeline's debug load port, releases the CPU, then reports halt status
// and final PC back over the UART transmitter.
module debug_loader #(
    parameter int                  len_data    = 32,
    parameter int                  len_addr    = 8,
    parameter logic [len_data-1:0] HALT_WORD   = 32'hFFFFFFFF,
    parameter logic [7:0]          CMD_LOAD    = 8'h01,
    parameter logic [7:0]          CMD_RUN     = 8'h02,
    parameter int                  RUN_TIMEOUT = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                tx_done,
    input  logic                halt_flag,
    input  logic [7:0]          in_pc,
    output logic                debug_flag,
    output logic [len_addr-1:0] addr_mem_inst,
    output logic [len_data-1:0] ins_to_mem,
    output logic                wea_ram_inst,
    output logic                cpu_reset,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                busy
);

    localparam int BYTES = len_data / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WD_W  = $clog2(RUN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(RUN_TIMEOUT - 1);
    localparam logic [7:0]       STAT_HALT  = 8'h00;
    localparam logic [7:0]       STAT_TMOUT = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RUN,
        TX_STAT,
        WAIT_STAT,
        TX_PC,
        WAIT_PC
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] byte_cnt;
    logic [WD_W-1:0]  watchdog;
    logic [7:0]       tx_reg;

    logic       load_start;
    logic       shift_en;
    logic       addr_inc;
    logic       addr_clr;
    logic       wd_clr;
    logic       wd_inc;
    logic       stat_load;
    logic [7:0] stat_val;
    logic       pc_load;

    // State register; reset always returns the loader to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the control strobes and port outputs for each state.
    always_comb begin
        next_state   = state;
        load_start   = 1'b0;
        shift_en     = 1'b0;
        addr_inc     = 1'b0;
        addr_clr     = 1'b0;
        wd_clr       = 1'b0;
        wd_inc       = 1'b0;
        stat_load    = 1'b0;
        stat_val     = STAT_HALT;
        pc_load      = 1'b0;
        debug_flag   = 1'b0;
        cpu_reset    = 1'b0;
        wea_ram_inst = 1'b0;
        tx_start     = 1'b0;
        tx_data      = tx_reg;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                debug_flag = 1'b1;
                cpu_reset  = 1'b1;
                if (rx_done) begin
                    if (rx_data == CMD_LOAD) begin
                        next_state = LOAD;
                        load_start = 1'b1;
                        addr_clr   = 1'b1;
                    end else if (rx_data == CMD_RUN) begin
                        next_state = RUN;
                        wd_clr     = 1'b1;
                    end
                end
            end
            LOAD: begin
                debug_flag = 1'b1;
                cpu_reset  = 1'b1;
                if (rx_done) begin
                    shift_en = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                debug_flag   = 1'b1;
                cpu_reset    = 1'b1;
                wea_ram_inst = 1'b1;
                if ((ins_to_mem == HALT_WORD) || (&addr_mem_inst)) begin
                    next_state = IDLE;
                    addr_clr   = 1'b1;
                end else begin
                    next_state = LOAD;
                    addr_inc   = 1'b1;
                end
            end
            RUN: begin
                wd_inc = 1'b1;
                if (halt_flag) begin
                    next_state = TX_STAT;
                    stat_load  = 1'b1;
                    stat_val   = STAT_HALT;
                end else if (watchdog == WD_LIMIT) begin
                    next_state = TX_STAT;
                    stat_load  = 1'b1;
                    stat_val   = STAT_TMOUT;
                end
            end
            TX_STAT: begin
                tx_start   = 1'b1;
                next_state = WAIT_STAT;
            end
            WAIT_STAT: begin
                if (tx_done) begin
                    next_state = TX_PC;
                end
            end
            TX_PC: begin
                tx_start   = 1'b1;
                tx_data    = in_pc;
                pc_load    = 1'b1;
                next_state = WAIT_PC;
            end
            WAIT_PC: begin
                if (tx_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: word assembly, write address, watchdog and the held transmit byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_mem_inst <= '0;
            ins_to_mem    <= '0;
            byte_cnt      <= '0;
            watchdog      <= '0;
            tx_reg        <= '0;
        end else begin
            if (addr_clr) begin
                addr_mem_inst <= '0;
            end else if (addr_inc) begin
                addr_mem_inst <= addr_mem_inst + 1'b1;
            end
            if (load_start) begin
                byte_cnt <= '0;
            end else if (shift_en) begin
                byte_cnt   <= byte_cnt + 1'b1;
                ins_to_mem <= {ins_to_mem[len_data-9:0], rx_data};
            end
            if (wd_clr) begin
                watchdog <= '0;
            end else if (wd_inc) begin
                watchdog <= watchdog + 1'b1;
            end
            if (stat_load) begin
                tx_reg <= stat_val;
            end else if (pc_load) begin
                tx_reg <= in_pc;
            end
        end
    end

endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: randomized bench for debug_loader with a transaction-level
// reference model (expected memory writes and UART bytes with their cycles).
module tb_debug_loader;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic        halt_flag;
    logic [7:0]  in_pc;
    logic        debug_flag;
    logic [7:0]  addr_mem_inst;
    logic [31:0] ins_to_mem;
    logic        wea_ram_inst;
    logic        cpu_reset;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;

    debug_loader #(
        .len_data    (32),
        .len_addr    (8),
        .HALT_WORD   (32'hFFFFFFFF),
        .CMD_LOAD    (8'h01),
        .CMD_RUN     (8'h02),
        .RUN_TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .tx_done       (tx_done),
        .halt_flag     (halt_flag),
        .in_pc         (in_pc),
        .debug_flag    (debug_flag),
        .addr_mem_inst (addr_mem_inst),
        .ins_to_mem    (ins_to_mem),
        .wea_ram_inst  (wea_ram_inst),
        .cpu_reset     (cpu_reset),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .busy          (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int cyc = 0;

    // Cycle index used to timestamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int         at;
        logic [7:0] data;
    } tx_t;

    wr_t wr_q[$];
    tx_t tx_q[$];

    int checks = 0;
    int errors = 0;
    bit chk_en   = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_held = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Compare process: every cycle, ownership/busy levels and any write or
    // transmit strobe are checked against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("debug_flag", 32'(debug_flag), 32'(exp_held));
            checkOutput("cpu_reset", 32'(cpu_reset), 32'(exp_held));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            if (wea_ram_inst) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)",
                             addr_mem_inst, ins_to_mem, cyc);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    checkOutput("write_cycle", 32'(cyc), 32'(e.at));
                    checkOutput("write_addr", 32'(addr_mem_inst), 32'(e.addr));
                    checkOutput("write_data", ins_to_mem, e.data);
                end
            end
            if (tx_start) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tx: got byte %0h, expected no tx_start (cycle %0d)",
                             tx_data, cyc);
                end else begin
                    tx_t t;
                    t = tx_q.pop_front();
                    checkOutput("tx_cycle", 32'(cyc), 32'(t.at));
                    checkOutput("tx_byte", 32'(tx_data), 32'(t.data));
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one rx byte strobe; returns 1 unit after the edge that sampled it.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic startLoad();
        applyStimulus(8'h01);
        exp_busy = 1'b1;
        idleCycles($urandom_range(1, 3));
    endtask

    // Sends one word MSB first and records the write it must produce at address a.
    task automatic loadWord(input logic [31:0] w, input logic [7:0] a);
        wr_t e;
        bit  last;
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(w[i*8 +: 8]);
            if (i != 0) idleCycles($urandom_range(1, 3));
        end
        e.at   = cyc;
        e.addr = a;
        e.data = w;
        wr_q.push_back(e);
        last = (w == 32'hFFFFFFFF) || (a == 8'hFF);
        if ($urandom_range(0, 1) == 1) begin
            applyStimulus(8'($urandom));
        end else begin
            idleCycles(1);
        end
        if (last) exp_busy = 1'b0;
        idleCycles($urandom_range(0, 2));
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'hFFFFFFFF) w = 32'h0BADF00D;
        return w;
    endfunction

    // Expects the status byte at stat_at, then handshakes both UART bytes.
    task automatic doReport(input logic [7:0] status, input int stat_at, input logic [7:0] pc);
        tx_t t;
        t.at   = stat_at;
        t.data = status;
        tx_q.push_back(t);
        idleCycles($urandom_range(1, 3));
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        t.at   = cyc;
        t.data = pc;
        tx_q.push_back(t);
        idleCycles($urandom_range(1, 3));
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        exp_busy = 1'b0;
        exp_held = 1'b1;
        idleCycles(2);
    endtask

    // Starts the CPU and raises halt after k cycles in RUN.
    task automatic runHalt(input int k, input logic [7:0] pc);
        in_pc = pc;
        applyStimulus(8'h02);
        exp_busy = 1'b1;
        exp_held = 1'b0;
        idleCycles(k);
        halt_flag = 1'b1;
        @(posedge clk);
        #1;
        halt_flag = 1'b0;
        doReport(8'h00, cyc, pc);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish by 3000000");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        tx_done   = 1'b0;
        halt_flag = 1'b0;
        in_pc     = 8'h00;
        idleCycles(3);
        checkOutput("rst_debug_flag", 32'(debug_flag), 32'd1);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_wea", 32'(wea_ram_inst), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_addr", 32'(addr_mem_inst), 32'd0);
        checkOutput("rst_ins", ins_to_mem, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        idleCycles(2);

        $display("[TB] directed load 12345678 + halt word");
        startLoad();
        loadWord(32'h12345678, 8'h00);
        loadWord(32'hFFFFFFFF, 8'h01);
        idleCycles(2);
        checkOutput("load_end_addr", 32'(addr_mem_inst), 32'd0);
        checkOutput("load_end_debug", 32'(debug_flag), 32'd1);

        $display("[TB] halt run, pc 1C");
        runHalt(5, 8'h1C);

        $display("[TB] watchdog timeout run");
        begin
            int c0;
            in_pc = 8'h5A;
            applyStimulus(8'h02);
            exp_busy = 1'b1;
            exp_held = 1'b0;
            c0 = cyc;
            idleCycles(TIMEOUT);
            doReport(8'hEE, c0 + TIMEOUT, 8'h5A);
        end

        $display("[TB] halt coinciding with timeout");
        runHalt(TIMEOUT - 1, 8'h77);

        $display("[TB] ignored bytes and tx_done in IDLE");
        applyStimulus(8'h7F);
        idleCycles(2);
        applyStimulus(8'h55);
        idleCycles(2);
        tx_done = 1'b1;
        idleCycles(1);
        tx_done = 1'b0;
        idleCycles(2);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_addr", 32'(addr_mem_inst), 32'd0);

        $display("[TB] reset mid-load");
        startLoad();
        applyStimulus(8'hAA);
        idleCycles(2);
        applyStimulus(8'hBB);
        idleCycles(1);
        reset   = 1'b1;
        rx_data = 8'h01;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rx_done  = 1'b0;
        exp_busy = 1'b0;
        checkOutput("midrst_addr", 32'(addr_mem_inst), 32'd0);
        checkOutput("midrst_ins", ins_to_mem, 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        idleCycles(2);
        startLoad();
        loadWord(32'hCAFEBABE, 8'h00);
        loadWord(32'hFFFFFFFF, 8'h01);
        idleCycles(2);

        $display("[TB] random programs");
        repeat (3) begin
            int n;
            n = $urandom_range(1, 5);
            startLoad();
            for (int a = 0; a < n; a++) loadWord(randWord(), 8'(a));
            loadWord(32'hFFFFFFFF, 8'(n));
            idleCycles($urandom_range(1, 3));
            runHalt($urandom_range(0, 12), 8'($urandom));
        end

        $display("[TB] full memory load, 256 words");
        startLoad();
        for (int a = 0; a < 256; a++) loadWord(randWord(), 8'(a));
        idleCycles(2);
        checkOutput("full_end_addr", 32'(addr_mem_inst), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h33);
            idleCycles(2);
        end
        checkOutput("full_end_busy", 32'(busy), 32'd0);

        idleCycles(5);
        checkOutput("pending_writes", 32'(wr_q.size()), 32'd0);
        checkOutput("pending_tx", 32'(tx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
